// File: rtl/yuv2rgb_stream_pipe.sv
// yuv2rgb_stream_pipe: 3-stage valid/ready YUV->RGB converter with frame pixel counter (define YUV2RGB_ROUND_EN for round-half-up)
module yuv2rgb_stream_pipe #(
   parameter int DW         = 8,
   parameter int COEF_W     = 20,
   parameter int FRAC       = 16,
   parameter int CY         = 76284,
   parameter int CRV        = 104595,
   parameter int CGU        = -25624,
   parameter int CGV        = -53281,
   parameter int CBU        = 132251,
   parameter int Y_OFF      = 16,
   parameter int C_OFF      = 128,
   parameter int NUM_PIXELS = 76800,
   parameter int CNT_W      = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_y,
   input  logic [DW-1:0]    in_u,
   input  logic [DW-1:0]    in_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_r,
   output logic [DW-1:0]    out_g,
   output logic [DW-1:0]    out_b,
   output logic             out_last,
   output logic [CNT_W-1:0] pix_count
);
   localparam int PW = COEF_W + DW + 1;
   localparam int SW = PW + 2;
   localparam logic signed [PW-1:0] K_Y  = PW'(CY);
   localparam logic signed [PW-1:0] K_RV = PW'(CRV);
   localparam logic signed [PW-1:0] K_GU = PW'(CGU);
   localparam logic signed [PW-1:0] K_GV = PW'(CGV);
   localparam logic signed [PW-1:0] K_BU = PW'(CBU);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << DW) - 1);
`ifdef YUV2RGB_ROUND_EN
   localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC - 1));
`else
   localparam logic signed [SW-1:0] RND = '0;
`endif

   logic                    v1_q, v2_q, v3_q;
   logic signed [DW:0]      yo_q, uo_q, vo_q, yo_d, uo_d, vo_d;
   logic signed [PW-1:0]    py_q, prv_q, pgu_q, pgv_q, pbu_q;
   logic signed [PW-1:0]    py_d, prv_d, pgu_d, pgv_d, pbu_d;
   logic [DW-1:0]           r_q, g_q, b_q, r_d, g_d, b_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    adv, xfer;

   function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] t;
      t = (s + RND) >>> FRAC;
      return t[SW-1] ? '0 : (t > MAXV) ? MAXV[DW-1:0] : t[DW-1:0];
   endfunction

   assign adv       = !v3_q | out_ready;
   assign xfer      = v3_q & out_ready;
   assign in_ready  = adv;
   assign out_valid = v3_q;
   assign out_r     = r_q;
   assign out_g     = g_q;
   assign out_b     = b_q;
   assign pix_count = cnt_q;
   assign out_last  = v3_q & (cnt_q == CNT_W'(NUM_PIXELS - 1));

   // Next values for every stage: offsets, the five products, clamped sums and the wrapping pixel index
   always_comb begin
      yo_d  = $signed({1'b0, in_y}) - $signed((DW+1)'(Y_OFF));
      uo_d  = $signed({1'b0, in_u}) - $signed((DW+1)'(C_OFF));
      vo_d  = $signed({1'b0, in_v}) - $signed((DW+1)'(C_OFF));
      py_d  = K_Y  * PW'(yo_q);
      prv_d = K_RV * PW'(vo_q);
      pgu_d = K_GU * PW'(uo_q);
      pgv_d = K_GV * PW'(vo_q);
      pbu_d = K_BU * PW'(uo_q);
      r_d   = sat(SW'(py_q) + SW'(prv_q));
      g_d   = sat(SW'(py_q) + SW'(pgu_q) + SW'(pgv_q));
      b_d   = sat(SW'(py_q) + SW'(pbu_q));
      cnt_d = (cnt_q == CNT_W'(NUM_PIXELS - 1)) ? '0 : cnt_q + 1'b1;
   end

   // Stage valids advance together on adv; clear flushes them and restarts the frame count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         cnt_q <= '0;
      end else if (clear) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
         end
         if (xfer) cnt_q <= cnt_d;
      end
   end

   // Data registers load only behind a valid pixel, so outputs hold while no pixel is presented
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         yo_q  <= '0;
         uo_q  <= '0;
         vo_q  <= '0;
         py_q  <= '0;
         prv_q <= '0;
         pgu_q <= '0;
         pgv_q <= '0;
         pbu_q <= '0;
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
      end else if (adv && !clear) begin
         if (in_valid) begin
            yo_q <= yo_d;
            uo_q <= uo_d;
            vo_q <= vo_d;
         end
         if (v1_q) begin
            py_q  <= py_d;
            prv_q <= prv_d;
            pgu_q <= pgu_d;
            pgv_q <= pgv_d;
            pbu_q <= pbu_d;
         end
         if (v2_q) begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
         end
      end
   end
endmodule
